// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding request to instruction memory,
// holds the returned word until the core consumes it or flushes it.
module inst_fetch #(
    parameter logic [31:0] RESET_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    output logic        imem_rsp_ready,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_fault,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr;
    logic        flush_pending;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        fault_q;
    logic [31:0] cnt_q;

    logic        load_addr;
    logic        load_miss;
    logic        load_rsp;
    logic        set_fp;
    logic        clr_fp;
    logic        inc_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        imem_rsp_ready = 1'b0;
        inst_valid     = 1'b0;
        load_addr      = 1'b0;
        load_miss      = 1'b0;
        load_rsp       = 1'b0;
        set_fp         = 1'b0;
        clr_fp         = 1'b0;
        inc_cnt        = 1'b0;
        unique case (state)
            IDLE: begin
                if (fetch_en && !flush) begin
                    if (pc[1:0] == 2'b00) begin
                        load_addr = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        load_miss = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            REQ: begin
                // The request must stay up once raised; a flush only
                // redirects where the eventual response goes.
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    clr_fp    = 1'b1;
                    state_nxt = (flush || flush_pending) ? DRAIN : WAIT;
                end else if (flush) begin
                    set_fp = 1'b1;
                end
            end
            WAIT: begin
                imem_rsp_ready = 1'b1;
                if (flush) begin
                    state_nxt = imem_rsp_valid ? IDLE : DRAIN;
                end else if (imem_rsp_valid) begin
                    load_rsp  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            DRAIN: begin
                imem_rsp_ready = 1'b1;
                if (imem_rsp_valid) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                inst_valid = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (inst_ready) begin
                    inc_cnt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr          <= 32'h0;
            flush_pending <= 1'b0;
            inst_q        <= RESET_INST;
            inst_pc_q     <= 32'h0;
            fault_q       <= 1'b0;
            cnt_q         <= 32'h0;
        end else begin
            if (load_addr) begin
                addr <= pc;
            end
            if (clr_fp) begin
                flush_pending <= 1'b0;
            end else if (set_fp) begin
                flush_pending <= 1'b1;
            end
            if (load_miss) begin
                inst_q    <= RESET_INST;
                inst_pc_q <= pc;
                fault_q   <= 1'b1;
            end else if (load_rsp) begin
                inst_q    <= imem_rsp_data;
                inst_pc_q <= addr;
                fault_q   <= imem_rsp_err;
            end
            if (inc_cnt) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign imem_req_addr = addr;
    assign inst          = inst_valid ? inst_q : RESET_INST;
    assign inst_pc       = inst_pc_q;
    assign fetch_fault   = fault_q;
    assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: handshake, stall, flush, fault and reset
// scenarios with hand-computed expectations.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_en;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_fault;
    logic [31:0] fetch_cnt;

    int passed = 0;
    int total  = 0;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .fetch_en       (fetch_en),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_ready (imem_rsp_ready),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .fetch_fault    (fetch_fault),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = 32'h80000000; fetch_en = 1'b1; flush = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0; imem_rsp_err = 1'b0; inst_ready = 1'b0;
        step();
        step();
        total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %0h want 0", imem_req_valid); else passed++;
        total++; if (imem_rsp_ready !== 1'b0) $display("FAIL rst_rsp_ready got %0h want 0", imem_rsp_ready); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid got %0h want 0", inst_valid); else passed++;
        total++; if (inst !== 32'h00000013) $display("FAIL rst_inst got %08h want 00000013", inst); else passed++;
        total++; if (inst_pc !== 32'h0) $display("FAIL rst_inst_pc got %08h want 0", inst_pc); else passed++;
        total++; if (fetch_fault !== 1'b0) $display("FAIL rst_fault got %0h want 0", fetch_fault); else passed++;
        total++; if (fetch_cnt !== 32'h0) $display("FAIL rst_cnt got %0d want 0", fetch_cnt); else passed++;
        fetch_en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        pc = 32'h80000000; fetch_en = 1'b1; imem_req_ready = 1'b1;
        step();
        fetch_en = 1'b0;
        total++; if (imem_req_valid !== 1'b1) $display("FAIL basic_req_valid got %0h want 1", imem_req_valid); else passed++;
        total++; if (imem_req_addr !== 32'h80000000) $display("FAIL basic_req_addr got %08h want 80000000", imem_req_addr); else passed++;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00100093;
        step();
        imem_req_ready = 1'b0;
        total++; if (imem_rsp_ready !== 1'b1) $display("FAIL basic_rsp_ready got %0h want 1", imem_rsp_ready); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL basic_early_valid got %0h want 0", inst_valid); else passed++;
        step();
        imem_rsp_valid = 1'b0;
        total++; if (inst_valid !== 1'b1) $display("FAIL basic_inst_valid got %0h want 1", inst_valid); else passed++;
        total++; if (inst !== 32'h00100093) $display("FAIL basic_inst got %08h want 00100093", inst); else passed++;
        total++; if (inst_pc !== 32'h80000000) $display("FAIL basic_inst_pc got %08h want 80000000", inst_pc); else passed++;
        total++; if (fetch_fault !== 1'b0) $display("FAIL basic_fault got %0h want 0", fetch_fault); else passed++;
        total++; if (imem_rsp_ready !== 1'b0) $display("FAIL basic_hold_rsp_ready got %0h want 0", imem_rsp_ready); else passed++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total++; if (fetch_cnt !== 32'd1) $display("FAIL basic_cnt got %0d want 1", fetch_cnt); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL basic_after_valid got %0h want 0", inst_valid); else passed++;
        total++; if (inst !== 32'h00000013) $display("FAIL basic_after_inst got %08h want 00000013", inst); else passed++;
    endtask

    task automatic test_stall();
        pc = 32'h80000010; fetch_en = 1'b1; imem_req_ready = 1'b0;
        step();
        fetch_en = 1'b0; pc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            total++; if (imem_req_valid !== 1'b1) $display("FAIL stall_req_valid[%0d] got %0h want 1", i, imem_req_valid); else passed++;
            total++; if (imem_req_addr !== 32'h80000010) $display("FAIL stall_addr[%0d] got %08h want 80000010", i, imem_req_addr); else passed++;
            total++; if (imem_rsp_ready !== 1'b0) $display("FAIL stall_rsp_ready[%0d] got %0h want 0", i, imem_rsp_ready); else passed++;
            step();
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL stall_req_drop got %0h want 0", imem_req_valid); else passed++;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000011;
        step();
        imem_rsp_valid = 1'b0;
        total++; if (inst !== 32'h00000011) $display("FAIL stall_inst got %08h want 00000011", inst); else passed++;
        total++; if (inst_pc !== 32'h80000010) $display("FAIL stall_inst_pc got %08h want 80000010", inst_pc); else passed++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total++; if (fetch_cnt !== 32'd2) $display("FAIL stall_cnt got %0d want 2", fetch_cnt); else passed++;
    endtask

    task automatic test_flush_wait();
        pc = 32'h80000020; fetch_en = 1'b1; imem_req_ready = 1'b1;
        step();
        fetch_en = 1'b0;
        step();
        imem_req_ready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (imem_rsp_ready !== 1'b1) $display("FAIL fw_drain_rsp_ready got %0h want 1", imem_rsp_ready); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL fw_drain_valid got %0h want 0", inst_valid); else passed++;
        step();
        total++; if (inst_valid !== 1'b0) $display("FAIL fw_drain_valid2 got %0h want 0", inst_valid); else passed++;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL fw_drain_req got %0h want 0", imem_req_valid); else passed++;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
        step();
        imem_rsp_valid = 1'b0;
        total++; if (inst_valid !== 1'b0) $display("FAIL fw_discard_valid got %0h want 0", inst_valid); else passed++;
        total++; if (imem_rsp_ready !== 1'b0) $display("FAIL fw_idle_rsp_ready got %0h want 0", imem_rsp_ready); else passed++;
        total++; if (fetch_cnt !== 32'd2) $display("FAIL fw_cnt got %0d want 2", fetch_cnt); else passed++;
        pc = 32'h80000024; fetch_en = 1'b1; imem_req_ready = 1'b1;
        step();
        fetch_en = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00200113;
        step();
        imem_req_ready = 1'b0;
        step();
        imem_rsp_valid = 1'b0;
        total++; if (inst !== 32'h00200113) $display("FAIL fw_next_inst got %08h want 00200113", inst); else passed++;
        total++; if (inst_pc !== 32'h80000024) $display("FAIL fw_next_pc got %08h want 80000024", inst_pc); else passed++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total++; if (fetch_cnt !== 32'd3) $display("FAIL fw_next_cnt got %0d want 3", fetch_cnt); else passed++;
    endtask

    task automatic test_misaligned();
        pc = 32'h80000002; fetch_en = 1'b1;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL mis_idle_req got %0h want 0", imem_req_valid); else passed++;
        step();
        fetch_en = 1'b0;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL mis_req got %0h want 0", imem_req_valid); else passed++;
        total++; if (inst_valid !== 1'b1) $display("FAIL mis_valid got %0h want 1", inst_valid); else passed++;
        total++; if (fetch_fault !== 1'b1) $display("FAIL mis_fault got %0h want 1", fetch_fault); else passed++;
        total++; if (inst !== 32'h00000013) $display("FAIL mis_inst got %08h want 00000013", inst); else passed++;
        total++; if (inst_pc !== 32'h80000002) $display("FAIL mis_pc got %08h want 80000002", inst_pc); else passed++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total++; if (fetch_cnt !== 32'd4) $display("FAIL mis_cnt got %0d want 4", fetch_cnt); else passed++;
    endtask

    task automatic test_bus_err();
        pc = 32'h80000040; fetch_en = 1'b1; imem_req_ready = 1'b1;
        step();
        fetch_en = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0; imem_rsp_err = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step();
        imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
        total++; if (inst_valid !== 1'b1) $display("FAIL err_valid got %0h want 1", inst_valid); else passed++;
        total++; if (fetch_fault !== 1'b1) $display("FAIL err_fault got %0h want 1", fetch_fault); else passed++;
        total++; if (inst_pc !== 32'h80000040) $display("FAIL err_pc got %08h want 80000040", inst_pc); else passed++;
        total++; if (inst !== 32'h0) $display("FAIL err_inst got %08h want 0", inst); else passed++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total++; if (fetch_cnt !== 32'd5) $display("FAIL err_cnt got %0d want 5", fetch_cnt); else passed++;
    endtask

    task automatic test_hold_flush();
        pc = 32'h80000050; fetch_en = 1'b1; imem_req_ready = 1'b1;
        step();
        fetch_en = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00300193;
        step();
        imem_req_ready = 1'b0;
        step();
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            total++; if (inst_valid !== 1'b1) $display("FAIL hf_valid[%0d] got %0h want 1", i, inst_valid); else passed++;
            total++; if (inst !== 32'h00300193) $display("FAIL hf_inst[%0d] got %08h want 00300193", i, inst); else passed++;
            step();
        end
        flush = 1'b1; inst_ready = 1'b1;
        step();
        flush = 1'b0; inst_ready = 1'b0;
        total++; if (inst_valid !== 1'b0) $display("FAIL hf_drop got %0h want 0", inst_valid); else passed++;
        total++; if (fetch_cnt !== 32'd5) $display("FAIL hf_cnt got %0d want 5", fetch_cnt); else passed++;
        total++; if (inst !== 32'h00000013) $display("FAIL hf_inst_idle got %08h want 00000013", inst); else passed++;
    endtask

    task automatic test_flush_req();
        pc = 32'h80000060; fetch_en = 1'b1; imem_req_ready = 1'b0;
        step();
        fetch_en = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (imem_req_valid !== 1'b1) $display("FAIL fr_req_kept got %0h want 1", imem_req_valid); else passed++;
        total++; if (imem_req_addr !== 32'h80000060) $display("FAIL fr_addr got %08h want 80000060", imem_req_addr); else passed++;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        total++; if (imem_rsp_ready !== 1'b1) $display("FAIL fr_drain_rsp_ready got %0h want 1", imem_rsp_ready); else passed++;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL fr_drain_req got %0h want 0", imem_req_valid); else passed++;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h12345678;
        step();
        imem_rsp_valid = 1'b0;
        total++; if (inst_valid !== 1'b0) $display("FAIL fr_valid got %0h want 0", inst_valid); else passed++;
        total++; if (imem_rsp_ready !== 1'b0) $display("FAIL fr_idle_rsp_ready got %0h want 0", imem_rsp_ready); else passed++;
        total++; if (fetch_cnt !== 32'd5) $display("FAIL fr_cnt got %0d want 5", fetch_cnt); else passed++;
    endtask

    task automatic test_idle_flush();
        pc = 32'h80000070; fetch_en = 1'b1; flush = 1'b1;
        step();
        fetch_en = 1'b0; flush = 1'b0;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL if_req got %0h want 0", imem_req_valid); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL if_valid got %0h want 0", inst_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        pc = 32'h80000080; fetch_en = 1'b1; imem_req_ready = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0; fetch_en = 1'b0;
        total++; if (imem_rsp_ready !== 1'b0) $display("FAIL rm_rsp_ready got %0h want 0", imem_rsp_ready); else passed++;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL rm_req got %0h want 0", imem_req_valid); else passed++;
        total++; if (fetch_cnt !== 32'h0) $display("FAIL rm_cnt got %0d want 0", fetch_cnt); else passed++;
        total++; if (inst_pc !== 32'h0) $display("FAIL rm_pc got %08h want 0", inst_pc); else passed++;
        total++; if (fetch_fault !== 1'b0) $display("FAIL rm_fault got %0h want 0", fetch_fault); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush_wait();
        test_misaligned();
        test_bus_err();
        test_hold_flush();
        test_flush_req();
        test_idle_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
